inst_cache: RTL and testbench

//  Direct-mapped instruction cache between the cpu instruction port (rom_addr/rom_ce/rom_data) and a slow,

---
 rtl/inst_cache_pkg.sv | 17 +
 rtl/inst_cache_line_ram.sv | 54 +++++
 rtl/inst_cache.sv | 123 ++++++++++++
 tb/tb_inst_cache.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared constants for the direct-mapped instruction cache: default geometry,
// FSM state codes and the tag-width helper.
package inst_cache_pkg;

   localparam int IC_INDEX_BITS  = 4;
   localparam int IC_OFFSET_BITS = 2;
   localparam int IC_ADDR_W      = 32;
   localparam int IC_DATA_W      = 32;

   localparam logic [0:0] IC_IDLE   = 1'b0;
   localparam logic [0:0] IC_REFILL = 1'b1;

   function automatic int ic_tag_bits(input int addr_w, input int index_bits, input int offset_bits);
      return addr_w - 2 - index_bits - offset_bits;
   endfunction

endpackage

// File: rtl/inst_cache_line_ram.sv
// Tag, valid and data storage for the instruction cache. Async read by index,
// sync word write, tag/valid commit at the end of a refill, and a flush-all clear.
module inst_cache_line_ram
   import inst_cache_pkg::*;
#(
   parameter int INDEX_BITS  = IC_INDEX_BITS,
   parameter int OFFSET_BITS = IC_OFFSET_BITS,
   parameter int TAG_BITS    = ic_tag_bits(IC_ADDR_W, IC_INDEX_BITS, IC_OFFSET_BITS),
   parameter int DATA_W      = IC_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INDEX_BITS-1:0]  rd_index,
   input  logic [OFFSET_BITS-1:0] rd_offset,
   output logic                   rd_valid,
   output logic [TAG_BITS-1:0]    rd_tag,
   output logic [DATA_W-1:0]      rd_data,
   input  logic                   wr_en,
   input  logic [INDEX_BITS-1:0]  wr_index,
   input  logic [OFFSET_BITS-1:0] wr_offset,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   commit_en,
   input  logic [TAG_BITS-1:0]    commit_tag,
   input  logic                   commit_valid,
   input  logic                   flush_all
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int WORDS = 1 << OFFSET_BITS;

   logic [LINES-1:0]    valid;
   logic [TAG_BITS-1:0] tag_arr  [LINES];
   logic [DATA_W-1:0]   data_arr [LINES][WORDS];

   // A commit in the same cycle as a flush carries commit_valid=0, so the order is harmless.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
      end else begin
         if (flush_all) valid <= '0;
         if (commit_en) valid[wr_index] <= commit_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)     data_arr[wr_index][wr_offset] <= wr_data;
      if (commit_en) tag_arr[wr_index]             <= commit_tag;
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_arr[rd_index];
   assign rd_data  = data_arr[rd_index][rd_offset];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: combinational hit path to the cpu fetch port,
// one-line burst refill over a req/ack memory bus on a miss.
//
//  state     | meaning
//  IC_IDLE   | serving lookups; a miss captures the line and starts a refill
//  IC_REFILL | requesting line words in order until the last word is acked
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int INDEX_BITS  = IC_INDEX_BITS,
   parameter int OFFSET_BITS = IC_OFFSET_BITS,
   parameter int ADDR_W      = IC_ADDR_W,
   parameter int DATA_W      = IC_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_ce_in,
   input  logic [ADDR_W-1:0] cpu_addr_in,
   output logic [DATA_W-1:0] cpu_data_out,
   output logic              stall_req_out,
   input  logic              flush_in,
   output logic              mem_req_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   input  logic              mem_ack_in,
   input  logic [DATA_W-1:0] mem_data_in
);

   localparam int TAG_BITS = ic_tag_bits(ADDR_W, INDEX_BITS, OFFSET_BITS);

   logic [0:0]             state;
   logic [OFFSET_BITS-1:0] word_cnt;
   logic                   flush_pending;
   logic [TAG_BITS-1:0]    line_tag;
   logic [INDEX_BITS-1:0]  line_index;

   logic [TAG_BITS-1:0]    cpu_tag;
   logic [INDEX_BITS-1:0]  cpu_index;
   logic [OFFSET_BITS-1:0] cpu_offset;
   logic                   addr_lsb_unused;

   logic                   rd_valid;
   logic [TAG_BITS-1:0]    rd_tag;
   logic [DATA_W-1:0]      rd_data;

   logic hit;
   logic refilling;
   logic word_ack;
   logic refill_last;
   logic flush_all;

   assign cpu_tag         = cpu_addr_in[ADDR_W-1 -: TAG_BITS];
   assign cpu_index       = cpu_addr_in[2+OFFSET_BITS +: INDEX_BITS];
   assign cpu_offset      = cpu_addr_in[2 +: OFFSET_BITS];
   assign addr_lsb_unused = ^cpu_addr_in[1:0];

   assign hit         = cpu_ce_in & rd_valid & (rd_tag == cpu_tag);
   assign refilling   = (state == IC_REFILL);
   assign word_ack    = refilling & mem_ack_in;
   assign refill_last = word_ack & (&word_cnt);
   // A flush arriving on the final ack still has to kill the line being committed.
   assign flush_all   = (~refilling & flush_in) | (refill_last & (flush_pending | flush_in));

   assign cpu_data_out  = hit ? rd_data : '0;
   assign stall_req_out = rst & cpu_ce_in & (refilling | ~hit);
   assign mem_req_out   = refilling;
   assign mem_addr_out  = refilling ? {line_tag, line_index, word_cnt, 2'b00} : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IC_IDLE;
         word_cnt      <= '0;
         flush_pending <= 1'b0;
         line_tag      <= '0;
         line_index    <= '0;
      end else begin
         case (state)
            IC_IDLE: begin
               flush_pending <= 1'b0;
               if (cpu_ce_in && !hit) begin
                  state      <= IC_REFILL;
                  line_tag   <= cpu_tag;
                  line_index <= cpu_index;
                  word_cnt   <= '0;
               end
            end
            default: begin
               if (flush_in) flush_pending <= 1'b1;
               if (mem_ack_in) begin
                  word_cnt <= word_cnt + OFFSET_BITS'(1);
                  if (&word_cnt) begin
                     state         <= IC_IDLE;
                     flush_pending <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   inst_cache_line_ram #(
      .INDEX_BITS  (INDEX_BITS),
      .OFFSET_BITS (OFFSET_BITS),
      .TAG_BITS    (TAG_BITS),
      .DATA_W      (DATA_W)
   ) u_line_ram (
      .clk          (clk),
      .rst          (rst),
      .rd_index     (cpu_index),
      .rd_offset    (cpu_offset),
      .rd_valid     (rd_valid),
      .rd_tag       (rd_tag),
      .rd_data      (rd_data),
      .wr_en        (word_ack),
      .wr_index     (line_index),
      .wr_offset    (word_cnt),
      .wr_data      (mem_data_in),
      .commit_en    (refill_last),
      .commit_tag   (line_tag),
      .commit_valid (~(flush_pending | flush_in)),
      .flush_all    (flush_all)
   );

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache: a backing-memory responder with
// configurable wait states, a table of hit vectors, and hand-written refill sequences.
module tb_inst_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_ce_in;
   logic [31:0] cpu_addr_in;
   logic [31:0] cpu_data_out;
   logic        stall_req_out;
   logic        flush_in;
   logic        mem_req_out;
   logic [31:0] mem_addr_out;
   logic        mem_ack_in;
   logic [31:0] mem_data_in;

   int checks = 0;
   int errors = 0;

   int          wait_states = 0;
   int          wcnt = 0;
   logic        prev_req = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] acked [$];

   typedef struct {
      logic        ce;
      logic [31:0] addr;
      logic        exp_stall;
      logic [31:0] exp_data;
   } vec_t;
   vec_t vecs [6];

   inst_cache dut (
      .clk           (clk),
      .rst           (rst),
      .cpu_ce_in     (cpu_ce_in),
      .cpu_addr_in   (cpu_addr_in),
      .cpu_data_out  (cpu_data_out),
      .stall_req_out (stall_req_out),
      .flush_in      (flush_in),
      .mem_req_out   (mem_req_out),
      .mem_addr_out  (mem_addr_out),
      .mem_ack_in    (mem_ack_in),
      .mem_data_in   (mem_data_in)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Backing memory: ack after wait_states idle cycles, data valid with the ack.
   always @(negedge clk) begin
      if (prev_req && !mem_ack_in) begin
         chk("req_held", {31'd0, mem_req_out}, 32'd1);
         chk("addr_stable", mem_addr_out, prev_addr);
      end
      if (mem_req_out) begin
         if (wcnt >= wait_states) begin
            mem_ack_in  = 1'b1;
            mem_data_in = mem_word(mem_addr_out);
            acked.push_back(mem_addr_out);
            wcnt = 0;
         end else begin
            mem_ack_in = 1'b0;
            wcnt++;
         end
      end else begin
         mem_ack_in = 1'b0;
         wcnt = 0;
      end
      prev_req  = mem_req_out;
      prev_addr = mem_addr_out;
   end

   // Starts and ends just after a rising edge; counts stalled cycles until the hit.
   task automatic fetch(input logic [31:0] addr, input int flush_cyc,
                        output int stalls, output logic [31:0] data);
      logic done;
      done   = 1'b0;
      stalls = 0;
      data   = '0;
      cpu_ce_in   = 1'b1;
      cpu_addr_in = addr;
      for (int c = 0; c < 200; c++) begin
         flush_in = (c == flush_cyc);
         @(negedge clk);
         if (!stall_req_out) begin
            data = cpu_data_out;
            done = 1'b1;
            break;
         end
         stalls++;
         @(posedge clk);
         #1;
      end
      chk("fetch_done", {31'd0, done}, 32'd1);
      @(posedge clk);
      #1;
      flush_in  = 1'b0;
      cpu_ce_in = 1'b0;
   endtask

   task automatic expect_acks(input string name, input logic [31:0] base, input int n);
      chk({name, "_ack_count"}, acked.size(), n);
      for (int i = 0; i < n && i < acked.size(); i++)
         chk({name, "_ack_addr"}, acked[i], base + 32'(4 * (i % 4)));
      acked.delete();
   endtask

   initial begin
      int          stalls;
      logic [31:0] data;

      vecs[0] = '{1'b1, 32'h104, 1'b0, mem_word(32'h104)};
      vecs[1] = '{1'b1, 32'h108, 1'b0, mem_word(32'h108)};
      vecs[2] = '{1'b1, 32'h10C, 1'b0, mem_word(32'h10C)};
      vecs[3] = '{1'b1, 32'h100, 1'b0, mem_word(32'h100)};
      vecs[4] = '{1'b0, 32'h104, 1'b0, 32'h0};
      vecs[5] = '{1'b1, 32'h103, 1'b0, mem_word(32'h100)};

      rst         = 1'b0;
      cpu_ce_in   = 1'b1;
      cpu_addr_in = 32'h100;
      flush_in    = 1'b0;
      mem_ack_in  = 1'b0;
      mem_data_in = '0;

      // Reset state: outputs quiet even with a fetch presented
      repeat (2) @(negedge clk);
      chk("rst_stall", {31'd0, stall_req_out}, 32'd0);
      chk("rst_data", cpu_data_out, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req_out}, 32'd0);
      chk("rst_mem_addr", mem_addr_out, 32'd0);
      cpu_ce_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Cold miss, zero-wait memory
      fetch(32'h100, -1, stalls, data);
      chk("cold_stalls", 32'(stalls), 32'd5);
      chk("cold_data", data, mem_word(32'h100));
      expect_acks("cold", 32'h100, 4);

      // Hits on the refilled line, one cycle each
      foreach (vecs[i]) begin
         cpu_ce_in   = vecs[i].ce;
         cpu_addr_in = vecs[i].addr;
         @(negedge clk);
         chk("vec_stall", {31'd0, stall_req_out}, {31'd0, vecs[i].exp_stall});
         chk("vec_data", cpu_data_out, vecs[i].exp_data);
         chk("vec_mem_req", {31'd0, mem_req_out}, 32'd0);
         @(posedge clk);
         #1;
      end
      cpu_ce_in = 1'b0;

      // Three wait states per word: 16 refill cycles plus the miss cycle
      wait_states = 3;
      fetch(32'h240, -1, stalls, data);
      chk("wait_stalls", 32'(stalls), 32'd17);
      chk("wait_data", data, mem_word(32'h240));
      expect_acks("wait", 32'h240, 4);
      wait_states = 0;

      // Conflict on index 0
      fetch(32'h500, -1, stalls, data);
      chk("conf_a_stalls", 32'(stalls), 32'd5);
      chk("conf_a_data", data, mem_word(32'h500));
      expect_acks("conf_a", 32'h500, 4);
      fetch(32'h108, -1, stalls, data);
      chk("conf_b_stalls", 32'(stalls), 32'd5);
      chk("conf_b_data", data, mem_word(32'h108));
      expect_acks("conf_b", 32'h100, 4);
      fetch(32'h10C, -1, stalls, data);
      chk("conf_hit_stalls", 32'(stalls), 32'd0);
      chk("conf_hit_data", data, mem_word(32'h10C));

      // Flush during word 2: burst completes, line stays invalid, refetch refills again
      fetch(32'h308, 3, stalls, data);
      chk("flush_stalls", 32'(stalls), 32'd10);
      chk("flush_data", data, mem_word(32'h308));
      expect_acks("flush", 32'h300, 8);
      fetch(32'h100, -1, stalls, data);
      chk("flush_all_stalls", 32'(stalls), 32'd5);
      chk("flush_all_data", data, mem_word(32'h100));
      expect_acks("flush_all", 32'h100, 4);

      // Flush in IDLE: same-cycle lookup still hits, next cycle misses
      cpu_ce_in   = 1'b1;
      cpu_addr_in = 32'h104;
      flush_in    = 1'b1;
      @(negedge clk);
      chk("idle_flush_stall", {31'd0, stall_req_out}, 32'd0);
      chk("idle_flush_data", cpu_data_out, mem_word(32'h104));
      @(posedge clk);
      #1;
      flush_in = 1'b0;
      @(negedge clk);
      chk("post_flush_stall", {31'd0, stall_req_out}, 32'd1);

      // Reset during word 1 of the resulting refill
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_mem_req", {31'd0, mem_req_out}, 32'd0);
      chk("mid_rst_mem_addr", mem_addr_out, 32'd0);
      chk("mid_rst_stall", {31'd0, stall_req_out}, 32'd0);
      chk("mid_rst_data", cpu_data_out, 32'd0);
      cpu_ce_in = 1'b0;
      repeat (2) @(negedge clk);
      acked.delete();
      rst = 1'b1;
      @(posedge clk);
      #1;
      fetch(32'h100, -1, stalls, data);
      chk("rst_refill_stalls", 32'(stalls), 32'd5);
      chk("rst_refill_data", data, mem_word(32'h100));
      expect_acks("rst_refill", 32'h100, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
